// File: rtl/quad_decoder_if.sv
// Quadrature decoder bus: encoder inputs and controls in, position and event pulses out.
interface quad_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a;
  logic             b;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] pos;
  logic             dir;
  logic             step;
  logic             err;
  logic             ovf;

  modport master (
    output a, b, en, clr,
    input  pos, dir, step, err, ovf
  );

  modport slave (
    input  a, b, en, clr,
    output pos, dir, step, err, ovf
  );
endinterface

// File: rtl/quad_decoder.sv
// x4 quadrature decoder with 2-flop input synchronizers, wrap-around position
// counter and one-cycle step/err/ovf pulses.
// Optional macro QDEC_FILTER_EN adds a 3-cycle per-channel glitch filter
// after the synchronizer (adds 3 cycles of latency and warm-up).
module quad_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  quad_decoder_if.slave bus
);

  localparam int unsigned SYNC_DEPTH = 2;
`ifdef QDEC_FILTER_EN
  localparam int unsigned FILT_DEPTH = 3;
`else
  localparam int unsigned FILT_DEPTH = 0;
`endif
  // One extra cycle so prev samples the value present at reset release
  // at the same edge a real transition would first be decoded.
  localparam int unsigned WARM_CYCLES = SYNC_DEPTH + FILT_DEPTH + 1;
  localparam int unsigned WARM_W      = 3;

  typedef enum logic {
    S_WARM = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // {a,b} packed as bit1 = a, bit0 = b throughout
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] acc;

  state_e            state_q, state_d;
  logic [WARM_W-1:0] wu_q, wu_d;
  logic [1:0]        prev_q, prev_d;
  logic [WIDTH-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        chg;
  logic              up;

  // Two-flop synchronizer on both encoder channels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {bus.a, bus.b};
      sync2_q <= sync1_q;
    end
  end

`ifdef QDEC_FILTER_EN
  logic [1:0]      acc_q, acc_d;
  logic [1:0][1:0] fcnt_q, fcnt_d;

  // Per channel: accept a new level only after it has held FILT_DEPTH cycles
  always_comb begin
    acc_d  = acc_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == acc_q[i]) begin
        fcnt_d[i] = 2'd0;
      end else if (fcnt_q[i] == 2'(FILT_DEPTH - 1)) begin
        acc_d[i]  = sync2_q[i];
        fcnt_d[i] = 2'd0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 2'd1;
      end
    end
  end

  // Glitch filter state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= 2'b00;
      fcnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign acc = acc_q;
`else
  assign acc = sync2_q;
`endif

  assign chg = acc ^ prev_q;
  // Gray order 00->01->11->10->00 is "up"; reduces to old a XOR new b
  assign up  = prev_q[1] ^ acc[0];

  // Warm-up sequencing, transition decode and position update
  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    prev_d  = prev_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      S_WARM: begin
        prev_d = acc;
        if (wu_q == WARM_W'(WARM_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          wu_d = wu_q + WARM_W'(1);
        end
      end
      S_RUN: begin
        if (chg != 2'b00) begin
          prev_d = acc;
          if (chg == 2'b11) begin
            err_d = 1'b1;
          end else begin
            step_d = 1'b1;
            dir_d  = up;
            if (bus.en && !bus.clr) begin
              if (up) begin
                pos_d = pos_q + WIDTH'(1);
                ovf_d = &pos_q;
              end else begin
                pos_d = pos_q - WIDTH'(1);
                ovf_d = ~|pos_q;
              end
            end
          end
        end
      end
      default: state_d = S_WARM;
    endcase
    // Synchronous clear wins over any simultaneous step
    if (bus.clr) begin
      pos_d = '0;
    end
  end

  // Decoder state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_WARM;
      wu_q    <= '0;
      prev_q  <= 2'b00;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wu_q    <= wu_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.pos  = pos_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;
  assign bus.err  = err_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized bench for quad_decoder against a Gray-index position model.
module tb_quad_decoder;

  localparam int unsigned WIDTH = 8;
  localparam int          MOD   = 1 << WIDTH;
`ifdef QDEC_FILTER_EN
  localparam int          LAT   = 6;
`else
  localparam int          LAT   = 3;
`endif
  localparam int          HOLD  = LAT + 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  quad_decoder_if #(.WIDTH(WIDTH)) bus ();

  quad_decoder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // reference state
  logic [1:0] m_ab  = 2'b00;
  int         m_pos = 0;
  logic       m_dir = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // position of a state along the Gray cycle 00,01,11,10
  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Apply one {a,b} change, optionally clear at the decode edge, and check the window
  task automatic xact(input logic [1:0] ab, input logic en_v, input logic clr_v, input string tag);
    int d, e_step, e_err, e_ovf;
    int steps, errs, ovfs, first_k;
    d = (gidx(ab) - gidx(m_ab) + 4) % 4;
    e_step = (d == 1 || d == 3) ? 1 : 0;
    e_err  = (d == 2) ? 1 : 0;
    e_ovf  = 0;
    if (e_step == 1) begin
      m_dir = (d == 1);
      if (!clr_v && en_v) begin
        if (d == 1) begin
          if (m_pos == MOD - 1) e_ovf = 1;
          m_pos = (m_pos + 1) % MOD;
        end else begin
          if (m_pos == 0) e_ovf = 1;
          m_pos = (m_pos + MOD - 1) % MOD;
        end
      end
    end
    if (clr_v) m_pos = 0;
    m_ab = ab;

    bus.a  = ab[1];
    bus.b  = ab[0];
    bus.en = en_v;
    steps = 0; errs = 0; ovfs = 0; first_k = -1;
    for (int k = 1; k <= HOLD; k++) begin
      @(posedge clk);
      #1;
      if (bus.step) steps++;
      if (bus.err)  errs++;
      if (bus.ovf)  ovfs++;
      if ((bus.step || bus.err) && first_k < 0) first_k = k;
      if (clr_v && k == LAT - 1) bus.clr = 1'b1;
      if (k == LAT) bus.clr = 1'b0;
    end
    check({tag, "/step"}, steps, e_step);
    check({tag, "/err"},  errs,  e_err);
    check({tag, "/ovf"},  ovfs,  e_ovf);
    check({tag, "/pos"},  int'(bus.pos), m_pos);
    check({tag, "/dir"},  int'(bus.dir), int'(m_dir));
    if (e_step + e_err > 0) check({tag, "/lat"}, first_k, LAT);
  endtask

  // Release reset and confirm warm-up produces no events
  task automatic release_reset();
    int ev;
    ev = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.step || bus.err || bus.ovf) ev++;
    end
    check("warmup/events", ev, 0);
    check("warmup/pos", int'(bus.pos), 0);
  endtask

`ifdef QDEC_FILTER_EN
  // Toggle a for len cycles then restore; filter passes only len >= 3
  task automatic pulse_a(input int len, input string tag);
    logic [1:0] mid;
    int steps, errs, e_steps;
    mid = {~m_ab[1], m_ab[0]};
    e_steps = (len >= 3) ? 2 : 0;
    if (e_steps == 2) m_dir = (((gidx(m_ab) - gidx(mid) + 4) % 4) == 1);
    steps = 0; errs = 0;
    bus.a = mid[1];
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k == len) bus.a = m_ab[1];
      if (bus.step) steps++;
      if (bus.err)  errs++;
    end
    check({tag, "/step"}, steps, e_steps);
    check({tag, "/err"},  errs,  0);
    check({tag, "/pos"},  int'(bus.pos), m_pos);
    check({tag, "/dir"},  int'(bus.dir), int'(m_dir));
  endtask
`endif

  initial begin
    bus.a = 1'b0; bus.b = 1'b0; bus.en = 1'b1; bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/pos",  int'(bus.pos),  0);
    check("rst/dir",  int'(bus.dir),  0);
    check("rst/step", int'(bus.step), 0);
    check("rst/err",  int'(bus.err),  0);
    check("rst/ovf",  int'(bus.ovf),  0);
    release_reset();

    // four up steps
    xact(2'b01, 1'b1, 1'b0, "up1");
    xact(2'b11, 1'b1, 1'b0, "up2");
    xact(2'b10, 1'b1, 1'b0, "up3");
    xact(2'b00, 1'b1, 1'b0, "up4");
    // down from zero wraps
    xact(2'b00, 1'b1, 1'b1, "clr0");
    xact(2'b10, 1'b1, 1'b0, "dnwrap");
    // both channels change
    xact(2'b01, 1'b1, 1'b0, "illegal");
    // clear colliding with an up step at pos 5
    xact(2'b01, 1'b1, 1'b1, "clr1");
    xact(2'b11, 1'b1, 1'b0, "to1");
    xact(2'b10, 1'b1, 1'b0, "to2");
    xact(2'b00, 1'b1, 1'b0, "to3");
    xact(2'b01, 1'b1, 1'b0, "to4");
    xact(2'b11, 1'b1, 1'b0, "to5");
    xact(2'b10, 1'b1, 1'b1, "clrstep");
    // counting disabled
    xact(2'b00, 1'b0, 1'b0, "hold1");
    xact(2'b01, 1'b0, 1'b0, "hold2");
    xact(2'b11, 1'b0, 1'b0, "hold3");
    // up wrap and disabled down at zero
    xact(2'b11, 1'b1, 1'b1, "clr2");
    xact(2'b01, 1'b1, 1'b0, "dn255");
    xact(2'b11, 1'b1, 1'b0, "upwrap");
    xact(2'b01, 1'b0, 1'b0, "dnhold");

`ifdef QDEC_FILTER_EN
    pulse_a(2, "glitch2");
    pulse_a(4, "pulse4");
`endif

    for (int i = 0; i < 150; i++) begin
      xact(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), "rand");
    end

    // asynchronous reset mid-operation
    xact(m_ab, 1'b1, 1'b1, "preclr");
    xact({m_ab[0], ~m_ab[1]}, 1'b1, 1'b0, "preup");
    bus.a = 1'b0; bus.b = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst/pos",  int'(bus.pos),  0);
    check("arst/dir",  int'(bus.dir),  0);
    check("arst/step", int'(bus.step), 0);
    m_ab = 2'b00; m_pos = 0; m_dir = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    xact(2'b10, 1'b1, 1'b0, "post1");
    xact(2'b11, 1'b1, 1'b0, "post2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, position counter width in bits (legal 4..16).
REQ-002 The block SHALL provide port clk  input  1  rising-edge system clock.
REQ-003 The block SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL provide port a  input  1  encoder channel A, asynchronous to clk.
REQ-005 The block SHALL provide port b  input  1  encoder channel B, asynchronous to clk.
REQ-006 The block SHALL provide port en  input  1  count enable; 0 holds pos.
REQ-007 The block SHALL provide port clr  input  1  synchronous clear of pos.
REQ-008 The block SHALL provide port pos  output  WIDTH  registered signed-agnostic position count.
REQ-009 The block SHALL provide port dir  output  1  direction of last valid step; 1 = up, 0 = down.
REQ-010 The block SHALL provide port step  output  1  one-cycle pulse per valid quadrature transition.
REQ-011 The block SHALL provide port err  output  1  one-cycle pulse on illegal transition (both channels changed).
REQ-012 The block SHALL provide port ovf  output  1  one-cycle pulse when pos wraps in either direction.

Function
REQ-013 a and b SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 The block SHALL hold prev = last accepted {a,b} and compare it with the current accepted {a,b} every clk.
REQ-015 Transitions 00->01, 01->11, 11->10, 10->00 SHALL be up steps (step=1, dir=1 next cycle).
REQ-016 Transitions 00->10, 10->11, 11->01, 01->00 SHALL be down steps (step=1, dir=0 next cycle).
REQ-017 Any transition changing both bits SHALL pulse err for one cycle, leave pos and dir unchanged, and update prev.
REQ-018 No change SHALL produce no step, no err, and no pos change.
REQ-019 Decoding SHALL be x4: each valid transition changes pos by exactly 1 when en=1.
REQ-020 pos SHALL wrap modulo 2^WIDTH; up from all-ones gives 0, down from 0 gives all-ones, and each wrap pulses ovf in the same cycle that pos updates.
REQ-021 en=0 SHALL hold pos and suppress ovf; step, dir, err SHALL still be reported.
REQ-022 clr=1 SHALL set pos to 0 on the next edge, overriding a simultaneous step and suppressing ovf; step, dir, err SHALL still be reported and prev SHALL still update.
REQ-023 Latency from a change on a or b to the step/err pulse SHALL be 3 clk edges without filter, 6 with filter.
REQ-024 pos, dir, step, err, ovf SHALL be driven directly from flops.
REQ-025 Input transitions arriving faster than one per clk after synchronization are unsupported; the block SHALL flag them only via err.

Reset
REQ-026 While rst=0: synchronizers, filter, prev = 00, pos = 0, dir = 0, step = err = ovf = 0.
REQ-027 After rst release, the block SHALL run a warm-up state for the synchronizer (and filter) depth during which prev loads the accepted inputs without generating step, err, or pos change.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately, regardless of clk.

Configuration
REQ-029 Macro QDEC_FILTER_EN SHALL compile in a per-channel glitch filter after the synchronizer.
REQ-030 With QDEC_FILTER_EN defined, a channel's accepted value SHALL change only after the synchronized input has held a new value for 3 consecutive clk cycles; shorter pulses are discarded.
REQ-031 Without QDEC_FILTER_EN, the synchronized value SHALL be the accepted value directly, and no filter logic SHALL be synthesized.

Verification
REQ-032 Reset, then apply the sequence {a,b} 00,01,11,10,00 with 8 clk between changes, en=1 -> pos=4, dir=1, 4 step pulses, err never asserts.
REQ-033 From pos=0, apply one down step (00->10) -> pos=255 (WIDTH=8), ovf pulses once, dir=0.
REQ-034 Apply 00->11 in one clk -> err pulses once, pos unchanged, step not asserted.
REQ-035 Assert clr in the same cycle that an up step is decoded with pos=5 -> pos=0, step=1, ovf=0.
REQ-036 With en=0, apply 3 up steps -> pos unchanged, 3 step pulses, dir=1.
REQ-037 With QDEC_FILTER_EN defined, apply a 2-cycle glitch on a -> no step; a 4-cycle pulse -> an up step then a down step, pos back to its starting value.
